// File: rtl/split2.sv
// ---------------------------------------------------------------------------
// split2 - two-output deterministic split (dispatch side of the grid router)
//
// Pops one packet at a time from an input buffer and writes it to one of two
// output buffers, steered by the signed DX field carried in the packet:
//   DX != 0 : forward port a, with |DX| reduced by one (never wraps)
//   DX == 0 : local/turn port b, packet passed through unchanged
//
// All state updates happen on the falling edge of clk. Reset is asynchronous
// and active-low. A packet that is held when reset asserts is dropped.
//
// Handshake: the input buffer is popped with a one-cycle read_en_in strobe
// while buffer_in_empty is low, and din is valid at the next falling edge.
// An output buffer is written with a one-cycle wen_x strobe with dout_x
// valid in the same cycle, and only at an edge where that buffer's full
// flag is low. At most one of read_en_in, wen_a and wen_b is high per cycle.
//
// Optional feature (macro SPLIT2_PKT_COUNT_EN): adds pkt_count_a/pkt_count_b,
// 16-bit saturating counts of wen_a/wen_b pulses, cleared by reset.
//
// Ports:
//   clk                input   clock, falling edge active
//   rst                input   asynchronous active-low reset
//   din                input   input buffer read data
//   buffer_in_empty    input   input buffer empty
//   buffer_out_a_full  input   forward buffer full
//   buffer_out_b_full  input   local buffer full
//   read_en_in         output  input buffer pop strobe
//   dout_a / wen_a     output  forward write data / strobe
//   dout_b / wen_b     output  local write data / strobe
//   pkt_count_a/_b     output  write counters (SPLIT2_PKT_COUNT_EN only)
//   dbg_state          output  current FSM state (0 IDLE, 1 FETCH, 2 SEND)
// ---------------------------------------------------------------------------
module split2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DX_LSB     = 23,
  parameter int DX_WIDTH   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  buffer_in_empty,
  input  logic                  buffer_out_a_full,
  input  logic                  buffer_out_b_full,
  output logic                  read_en_in,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  wen_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  wen_b,
`ifdef SPLIT2_PKT_COUNT_EN
  output logic [15:0]           pkt_count_a,
  output logic [15:0]           pkt_count_b,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam logic [DX_WIDTH-1:0] DX_ONE = {{(DX_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    sel_a_q, sel_a_d;
  logic                    read_en_q, read_en_d;
  logic                    wen_a_q, wen_a_d;
  logic                    wen_b_q, wen_b_d;
  logic [DATA_WIDTH-1:0]   dout_a_q, dout_a_d;
  logic [DATA_WIDTH-1:0]   dout_b_q, dout_b_d;

  // Next-hop decode of the incoming word.
  logic [DX_WIDTH-1:0]     dx;
  logic [DX_WIDTH-1:0]     dx_new;
  logic                    dx_nonzero;
  logic [DATA_WIDTH-1:0]   next_pkt;
  logic                    target_full;

  // Step DX one unit toward zero. Because the magnitude only ever shrinks,
  // the most-negative value moves to most-negative+1 and nothing can wrap.
  always_comb begin
    dx         = din[DX_LSB +: DX_WIDTH];
    dx_nonzero = |dx;
    dx_new     = dx;
    if (dx_nonzero) begin
      if (dx[DX_WIDTH-1]) dx_new = dx + DX_ONE;
      else                dx_new = dx - DX_ONE;
    end
    next_pkt = din;
    next_pkt[DX_LSB +: DX_WIDTH] = dx_new;
  end

  // Only the selected port's full flag can stall the held packet.
  assign target_full = sel_a_q ? buffer_out_a_full : buffer_out_b_full;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_a_d   = sel_a_q;
    read_en_d = 1'b0;
    wen_a_d   = 1'b0;
    wen_b_d   = 1'b0;
    dout_a_d  = dout_a_q;
    dout_b_d  = dout_b_q;
    unique case (state_q)
      IDLE: begin
        if (!buffer_in_empty) begin
          read_en_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // din is valid on this edge, one edge after the pop strobe.
        hold_d  = next_pkt;
        sel_a_d = dx_nonzero;
        state_d = SEND;
      end
      SEND: begin
        if (!target_full) begin
          if (sel_a_q) begin
            wen_a_d  = 1'b1;
            dout_a_d = hold_q;
          end else begin
            wen_b_d  = 1'b1;
            dout_b_d = hold_q;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      sel_a_q   <= 1'b0;
      read_en_q <= 1'b0;
      wen_a_q   <= 1'b0;
      wen_b_q   <= 1'b0;
      dout_a_q  <= '0;
      dout_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sel_a_q   <= sel_a_d;
      read_en_q <= read_en_d;
      wen_a_q   <= wen_a_d;
      wen_b_q   <= wen_b_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
    end
  end

  assign read_en_in = read_en_q;
  assign wen_a      = wen_a_q;
  assign wen_b      = wen_b_q;
  assign dout_a     = dout_a_q;
  assign dout_b     = dout_b_q;
  assign dbg_state  = state_q;

`ifdef SPLIT2_PKT_COUNT_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Counters advance on the same edge that raises the write strobe.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (wen_a_d && (cnt_a_q != 16'hFFFF)) cnt_a_d = cnt_a_q + 16'd1;
    if (wen_b_d && (cnt_b_q != 16'hFFFF)) cnt_b_d = cnt_b_q + 16'd1;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign pkt_count_a = cnt_a_q;
  assign pkt_count_b = cnt_b_q;
`endif

endmodule
